pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//   Central stall/flush sequencer for the 5-stage RISC-V pipeline. Merges stall requests from IF/ID/MEM
//   into the per-register stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
//   Turns an EX-stage branch mispredict into one flush pulse plus a PC redirect, and defers it
//   while MEM holds the pipeline frozen, so id_ex (which ignores flush when stall[2]=1) never loses it.
// PARAMETERS
//   PIPE_DEPTH  6   stall vector width; bit0=PC, 1=IF/ID, 2=ID/EX, 3=EX/MEM, 4=MEM/WB, 5=spare
//   ADDR_W      32  PC / redirect address width
//   PERF_W      32  performance counter width
// PORTS
//   clk              in   1           system clock, all state on posedge
//   rst              in   1           asynchronous, active-high reset
//   if_stall_req     in   1           IF waiting on instruction fetch
//   id_stall_req     in   1           ID load-use hazard, needs one bubble
//   mem_stall_req    in   1           MEM waiting on data memory
//   ex_mispredict    in   1           EX resolved branch/jump != prediction
//   ex_target        in   ADDR_W      correct next PC from EX
//   stall            out  PIPE_DEPTH  per-register stall vector (1 = hold)
//   flush            out  1           kill IF/ID and ID/EX contents this cycle
//   redirect_valid   out  1           load redirect_addr into PC this cycle
//   redirect_addr    out  ADDR_W      redirect target
//   perf_stall_cyc   out  PERF_W      cycles with any stall bit set
//   perf_flush_cnt   out  PERF_W      flush pulses issued
//   perf_defer_cnt   out  PERF_W      mispredicts deferred by MEM stall
// BEHAVIOUR
//   - States: RUN, PEND. Registers: state, pend_target[ADDR_W].
//   - Reset (async, any time incl. PEND): state=RUN, pend_target=0, counters=0; outputs all 0 while rst=1.
//   - flush_now = (RUN & ex_mispredict & !mem_stall_req) | (PEND & !mem_stall_req). Combinational, same cycle.
//   - stall priority (combinational):
//       mem_stall_req          -> stall = 6'b011111 (EX/MEM and earlier frozen; MEM/WB takes bubble)
//       else flush_now         -> stall = 0 (overrides id_stall_req and if_stall_req; wrong path)
//       else id_stall_req      -> stall = 6'b000111 (ID/EX inserts bubble since stall[2]&!stall[3])
//       else if_stall_req      -> stall = 6'b000011
//       else                   -> stall = 0
//   - flush = flush_now; redirect_valid = flush_now.
//   - redirect_addr = (state==PEND) ? pend_target : ex_target; 0 when redirect_valid=0.
//   - Transitions:
//       RUN : ex_mispredict & mem_stall_req -> PEND, pend_target<=ex_target; otherwise stay RUN.
//       PEND: mem_stall_req -> stay PEND (ex_mispredict/ex_target ignored: same frozen instruction);
//             !mem_stall_req -> RUN (flush issued this cycle).
//   - Latency: undeferred mispredict flushes in the detection cycle (0 cycles); deferred flush in the
//     first cycle mem_stall_req is low. Exactly one flush pulse per mispredicting instruction.
//   - A mispredict in the cycle after a flush is a new instruction and is honoured normally.
// CONFIGURATION
//   PIPE_CTRL_PERF_EN defined: perf_stall_cyc += (stall!=0); perf_flush_cnt += flush;
//     perf_defer_cnt += (RUN->PEND transition). Counters wrap modulo 2^PERF_W, reset to 0.
//   PIPE_CTRL_PERF_EN undefined: no counter flops; all perf_* outputs tied to 0. Ports unchanged.
// TESTING
//   1 id_stall_req=1 one cycle, others 0 -> stall=6'b000111 that cycle, 0 next; flush=0.
//   2 ex_mispredict=1, ex_target=0x0000_1040, no stalls -> same cycle flush=1, redirect_valid=1,
//     redirect_addr=0x1040, stall=0; state stays RUN.
//   3 mem_stall_req=1 for cycles 0..3, ex_mispredict=1 target 0x200 in cycles 0..3 (target changes to
//     0x300 in cycle 2) -> cycles 0..3 stall=6'b011111, flush=0; cycle 4 flush=1, redirect_addr=0x200, single pulse.
//   4 ex_mispredict & id_stall_req & if_stall_req same cycle -> flush=1, stall=0, redirect_valid=1.
//   5 in PEND assert rst mid-cycle -> state=RUN immediately, all outputs 0; after release with
//     mem_stall_req=0 no flush is issued.
//   6 PIPE_CTRL_PERF_EN: run tests 1-3 back-to-back -> perf_stall_cyc=5, perf_flush_cnt=2,
//     perf_defer_cnt=1; without macro all perf_* read 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer: merges stall requests and defers mispredict flushes past MEM stalls.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int PIPE_DEPTH = 6,
    parameter int ADDR_W     = 32,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_stall_req,
    input  logic                  id_stall_req,
    input  logic                  mem_stall_req,
    input  logic                  ex_mispredict,
    input  logic [ADDR_W-1:0]     ex_target,
    output logic [PIPE_DEPTH-1:0] stall,
    output logic                  flush,
    output logic                  redirect_valid,
    output logic [ADDR_W-1:0]     redirect_addr,
    output logic [PERF_W-1:0]     perf_stall_cyc,
    output logic [PERF_W-1:0]     perf_flush_cnt,
    output logic [PERF_W-1:0]     perf_defer_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_e;

    localparam logic [PIPE_DEPTH-1:0] STALL_MEM =
        {{(PIPE_DEPTH-5){1'b0}}, 5'b11111};
    localparam logic [PIPE_DEPTH-1:0] STALL_ID =
        {{(PIPE_DEPTH-3){1'b0}}, 3'b111};
    localparam logic [PIPE_DEPTH-1:0] STALL_IF =
        {{(PIPE_DEPTH-2){1'b0}}, 2'b11};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pend_q, pend_d;
    logic                flush_now;
    logic [PIPE_DEPTH-1:0] stall_d;
    logic [ADDR_W-1:0]   raddr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        flush_now = 1'b0;
        stall_d   = '0;
        raddr_d   = '0;

        unique case (state_q)
            RUN: begin
                if (ex_mispredict && mem_stall_req) begin
                    state_d = PEND;
                    pend_d  = ex_target;
                end
                flush_now = ex_mispredict && !mem_stall_req;
            end
            PEND: begin
                // The frozen EX instruction is the one already captured; ignore EX inputs.
                if (!mem_stall_req) begin
                    state_d   = RUN;
                    flush_now = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        if (mem_stall_req)
            stall_d = STALL_MEM;
        else if (flush_now)
            stall_d = '0;
        else if (id_stall_req)
            stall_d = STALL_ID;
        else if (if_stall_req)
            stall_d = STALL_IF;

        if (flush_now)
            raddr_d = (state_q == PEND) ? pend_q : ex_target;
    end

    // Combinational outputs are forced quiet while reset is held.
    assign stall          = rst ? '0   : stall_d;
    assign flush          = rst ? 1'b0 : flush_now;
    assign redirect_valid = rst ? 1'b0 : flush_now;
    assign redirect_addr  = rst ? '0   : raddr_d;

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] stall_cyc_q, flush_cnt_q, defer_cnt_q;
    logic              defer_go;

    assign defer_go = (state_q == RUN) && (state_d == PEND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cyc_q <= '0;
            flush_cnt_q <= '0;
            defer_cnt_q <= '0;
        end else begin
            if (|stall_d)
                stall_cyc_q <= stall_cyc_q + 1'b1;
            if (flush_now)
                flush_cnt_q <= flush_cnt_q + 1'b1;
            if (defer_go)
                defer_cnt_q <= defer_cnt_q + 1'b1;
        end
    end

    assign perf_stall_cyc = stall_cyc_q;
    assign perf_flush_cnt = flush_cnt_q;
    assign perf_defer_cnt = defer_cnt_q;
`else
    assign perf_stall_cyc = '0;
    assign perf_flush_cnt = '0;
    assign perf_defer_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors, expectations queued,
// monitor compares on the falling edge.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_stall_req = 1'b0;
    logic        id_stall_req = 1'b0;
    logic        mem_stall_req = 1'b0;
    logic        ex_mispredict = 1'b0;
    logic [31:0] ex_target = '0;
    logic [5:0]  stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_defer_cnt;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [5:0]  stall;
        logic        flush;
        logic        rv;
        logic [31:0] raddr;
        bit          chk_perf;
        logic [31:0] p_stall;
        logic [31:0] p_flush;
        logic [31:0] p_defer;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    pipe_ctrl #(
        .PIPE_DEPTH(6),
        .ADDR_W(32),
        .PERF_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_stall_req(if_stall_req),
        .id_stall_req(id_stall_req),
        .mem_stall_req(mem_stall_req),
        .ex_mispredict(ex_mispredict),
        .ex_target(ex_target),
        .stall(stall),
        .flush(flush),
        .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr),
        .perf_stall_cyc(perf_stall_cyc),
        .perf_flush_cnt(perf_flush_cnt),
        .perf_defer_cnt(perf_defer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".stall"}, {26'd0, stall}, {26'd0, e.stall});
            chk({e.name, ".flush"}, {31'd0, flush}, {31'd0, e.flush});
            chk({e.name, ".rv"}, {31'd0, redirect_valid}, {31'd0, e.rv});
            chk({e.name, ".raddr"}, redirect_addr, e.raddr);
            if (e.chk_perf) begin
                chk({e.name, ".pstall"}, perf_stall_cyc, e.p_stall);
                chk({e.name, ".pflush"}, perf_flush_cnt, e.p_flush);
                chk({e.name, ".pdefer"}, perf_defer_cnt, e.p_defer);
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic i_f,
                        input logic i_d, input logic m, input logic mis,
                        input logic [31:0] t, input logic [5:0] e_st,
                        input logic e_fl, input logic [31:0] e_ad);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        if_stall_req = i_f;
        id_stall_req = i_d;
        mem_stall_req = m;
        ex_mispredict = mis;
        ex_target = t;
        e.name = nm;
        e.stall = e_st;
        e.flush = e_fl;
        e.rv = e_fl;
        e.raddr = e_ad;
        e.chk_perf = 1'b0;
        e.p_stall = '0;
        e.p_flush = '0;
        e.p_defer = '0;
        exp_q.push_back(e);
    endtask

    task automatic perf_step(input string nm, input logic [31:0] ps,
                             input logic [31:0] pf, input logic [31:0] pd);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if_stall_req = 1'b0;
        id_stall_req = 1'b0;
        mem_stall_req = 1'b0;
        ex_mispredict = 1'b0;
        ex_target = '0;
        e.name = nm;
        e.stall = '0;
        e.flush = 1'b0;
        e.rv = 1'b0;
        e.raddr = '0;
        e.chk_perf = 1'b1;
        e.p_stall = PE ? ps : 32'd0;
        e.p_flush = PE ? pf : 32'd0;
        e.p_defer = PE ? pd : 32'd0;
        exp_q.push_back(e);
    endtask

    initial begin
        // Reset held with busy inputs: everything quiet.
        step("rst", 1, 1, 1, 1, 1, 32'h55, 6'b000000, 0, 32'h0);
        step("idle0", 0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);
        // Test 1: one-cycle load-use bubble.
        step("t1_id", 0, 0, 1, 0, 0, 32'h0, 6'b000111, 0, 32'h0);
        step("t1_after", 0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);
        // Test 2: undeferred mispredict.
        step("t2_mis", 0, 0, 0, 0, 1, 32'h1040, 6'b000000, 1, 32'h1040);
        // Test 3: mispredict deferred through a 4-cycle MEM stall.
        step("t3_c0", 0, 0, 0, 1, 1, 32'h200, 6'b011111, 0, 32'h0);
        step("t3_c1", 0, 0, 0, 1, 1, 32'h200, 6'b011111, 0, 32'h0);
        step("t3_c2", 0, 0, 0, 1, 1, 32'h300, 6'b011111, 0, 32'h0);
        step("t3_c3", 0, 0, 0, 1, 1, 32'h300, 6'b011111, 0, 32'h0);
        step("t3_c4", 0, 0, 0, 0, 0, 32'h300, 6'b000000, 1, 32'h200);
        step("t3_c5", 0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);
        perf_step("t6_perf", 32'd5, 32'd2, 32'd1);
        // Test 4: flush beats ID and IF stalls.
        step("t4_all", 0, 1, 1, 0, 1, 32'h80, 6'b000000, 1, 32'h80);
        step("t4_next", 0, 0, 0, 0, 1, 32'h84, 6'b000000, 1, 32'h84);
        step("if_only", 0, 1, 0, 0, 0, 32'h0, 6'b000011, 0, 32'h0);
        step("mem_id", 0, 1, 1, 1, 0, 32'h0, 6'b011111, 0, 32'h0);
        step("idle1", 0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);
        // Test 5: reset while a flush is pending drops it.
        step("t5_pend", 0, 0, 0, 1, 1, 32'h900, 6'b011111, 0, 32'h0);
        step("t5_rst", 0, 0, 0, 1, 0, 32'h0, 6'b000000, 0, 32'h0);
        #1 rst = 1'b1;
        step("t5_rel", 0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);
        perf_step("t5_perf", 32'd0, 32'd0, 32'd0);
        @(posedge clk);
        @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
